// File: rtl/tia_write_sequencer.sv
// tia_write_sequencer
//   Takes queued TIA register writes from a host and drives them onto the
//   write-decode bus as 6507-style CPU bus cycles. Each CPU cycle lasts
//   PHI_DIV colour clocks. phi2 is high in phase 0 only. w_bar stays low for
//   the whole CPU cycle of an issued write. A write to WSYNC (0x02) holds back
//   further issue until the horizontal counter signals the start of the next
//   line.
//
//   Ports
//     clk         colour clock, rising-edge
//     reset_bar   synchronous active-low reset
//     in_valid    host write request
//     in_ready    FIFO not full (registered)
//     in_addr     TIA register address of the request
//     in_data     TIA register data of the request
//     line_start  one-clock start-of-line pulse
//     a, d        address and data presented to the write decoder
//     phi2        CPU phase clock
//     w_bar       low while a write cycle is on the bus
//     wsyn_stall  high while halted waiting for line_start
//     count       FIFO occupancy
//
//   state | meaning
//   RUN   | writes issue at each CPU-cycle boundary while the FIFO has data
//   STALL | WSYNC halt; nothing issues until a captured line_start
module tia_write_sequencer #(
    parameter int DEPTH   = 8,
    parameter int PHI_DIV = 3
) (
    input  logic                     clk,
    input  logic                     reset_bar,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0]               in_addr,
    input  logic [7:0]               in_data,
    input  logic                     line_start,
    output logic [5:0]               a,
    output logic [7:0]               d,
    output logic                     phi2,
    output logic                     w_bar,
    output logic                     wsyn_stall,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(PHI_DIV);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PHI_DIV - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [5:0]    WSYNC_ADDR = 6'h02;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] phase_q;
    logic          boundary;
    logic [5:0]    mem_addr [DEPTH];
    logic [7:0]    mem_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_d;
    logic          push;
    logic          issue;
    logic          window;
    logic          credit_q;
    logic          wsync_cycle_q;
    logic          line_seen;

    // The edge at which phase returns to 0 is the CPU-cycle boundary.
    assign boundary  = (phase_q == PHASE_LAST);
    assign push      = in_valid & in_ready;
    // A pulse arriving on the boundary edge itself still counts.
    assign line_seen = credit_q | line_start;
    assign count_d   = count + CW'(push) - CW'(issue);

    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (boundary) begin
            if (state_q == RUN) begin
                if (wsync_cycle_q && !line_seen) begin
                    state_d = STALL;
                end
            end else if (line_seen) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        issue      = boundary && (state_d == RUN) && (count != '0);
        // Line-start credit is collected from phase 1 of the WSYNC cycle on.
        window     = (state_q == STALL) || (wsync_cycle_q && (phase_q != '0));
        wsyn_stall = (state_q == STALL);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= in_addr;
            mem_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_bar) begin
            phase_q       <= '0;
            phi2          <= 1'b1;
            w_bar         <= 1'b1;
            a             <= '0;
            d             <= '0;
            count         <= '0;
            in_ready      <= 1'b1;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            credit_q      <= 1'b0;
            wsync_cycle_q <= 1'b0;
        end else begin
            phase_q  <= boundary ? '0 : phase_q + 1'b1;
            phi2     <= boundary;
            count    <= count_d;
            in_ready <= (count_d != FULL_COUNT);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (boundary) begin
                w_bar         <= !issue;
                wsync_cycle_q <= issue && (mem_addr[rd_ptr] == WSYNC_ADDR);
                credit_q      <= 1'b0;
            end else if (window && line_start) begin
                credit_q <= 1'b1;
            end
            if (issue) begin
                a      <= mem_addr[rd_ptr];
                d      <= mem_data[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tia_write_sequencer.sv
module tb_tia_write_sequencer;

    logic       clk = 1'b0;
    logic       reset_bar;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_addr;
    logic [7:0] in_data;
    logic       line_start;
    logic [5:0] a;
    logic [7:0] d;
    logic       phi2;
    logic       w_bar;
    logic       wsyn_stall;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    logic [5:0] fa [8] = '{6'h03, 6'h2D, 6'h3F, 6'h10, 6'h04, 6'h2A, 6'h1C, 6'h3E};
    logic [7:0] fd [8] = '{8'h5A, 8'hA5, 8'h00, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78};

    always #5 clk = ~clk;

    tia_write_sequencer #(.DEPTH(8), .PHI_DIV(3)) dut (
        .clk        (clk),
        .reset_bar  (reset_bar),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .line_start (line_start),
        .a          (a),
        .d          (d),
        .phi2       (phi2),
        .w_bar      (w_bar),
        .wsyn_stall (wsyn_stall),
        .count      (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After this returns the reset edge has passed: phase 0, and the k-th
    // following edge leaves phase k mod 3; boundaries are edges 3, 6, 9, ...
    task automatic do_reset();
        reset_bar  = 1'b0;
        in_valid   = 1'b0;
        line_start = 1'b0;
        in_addr    = 6'h00;
        in_data    = 8'h00;
        tick();
        reset_bar = 1'b1;
    endtask

    task automatic test_reset();
        logic exp_phi2;
        do_reset();
        checks++;
        if ({a, d, phi2, w_bar, wsyn_stall, count, in_ready} !== {6'h00, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs got a=%h d=%h phi2=%b w_bar=%b stall=%b count=%0d rdy=%b exp a=00 d=00 phi2=1 w_bar=1 stall=0 count=0 rdy=1",
                     a, d, phi2, w_bar, wsyn_stall, count, in_ready);
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_phi2 = ((k % 3) == 0);
            checks++;
            if (phi2 !== exp_phi2) begin
                errors++;
                $display("FAIL reset_phi2 edge=%0d got=%b exp=%b", k, phi2, exp_phi2);
            end
            checks++;
            if ({w_bar, count, in_ready} !== {1'b1, 4'd0, 1'b1}) begin
                errors++;
                $display("FAIL reset_idle edge=%0d got w_bar=%b count=%0d rdy=%b exp 1 0 1", k, w_bar, count, in_ready);
            end
        end
    endtask

    task automatic test_two_writes();
        logic       exp_w;
        logic [5:0] exp_a;
        logic [7:0] exp_d;
        do_reset();
        in_valid = 1'b1; in_addr = 6'h09; in_data = 8'h44;
        tick();
        checks++;
        if (count !== 4'd1) begin
            errors++;
            $display("FAIL two_count1 got=%0d exp=1", count);
        end
        in_addr = 6'h0D; in_data = 8'hF0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 4'd2) begin
            errors++;
            $display("FAIL two_count2 got=%0d exp=2", count);
        end
        for (int k = 3; k <= 9; k++) begin
            tick();
            exp_w = (k >= 3 && k <= 8) ? 1'b0 : 1'b1;
            exp_a = (k < 6) ? 6'h09 : 6'h0D;
            exp_d = (k < 6) ? 8'h44 : 8'hF0;
            checks++;
            if ({w_bar, a, d} !== {exp_w, exp_a, exp_d}) begin
                errors++;
                $display("FAIL two_bus edge=%0d got w_bar=%b a=%h d=%h exp w_bar=%b a=%h d=%h",
                         k, w_bar, a, d, exp_w, exp_a, exp_d);
            end
        end
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL two_count_end got=%0d exp=0", count);
        end
    endtask

    task automatic test_fill();
        do_reset();
        in_valid = 1'b1; in_addr = 6'h02; in_data = 8'h00;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_addr = fa[i]; in_data = fd[i];
            tick();
            checks++;
            if (count !== 4'(i + 1)) begin
                errors++;
                $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1);
            end
        end
        checks++;
        if ({in_ready, wsyn_stall} !== 2'b01) begin
            errors++;
            $display("FAIL fill_full got rdy=%b stall=%b exp rdy=0 stall=1", in_ready, wsyn_stall);
        end
        in_addr = 6'h01; in_data = 8'hEE;
        tick();
        checks++;
        if ({count, in_ready} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL fill_ninth got count=%0d rdy=%b exp count=8 rdy=0", count, in_ready);
        end
        in_valid = 1'b0; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        checks++;
        if ({wsyn_stall, w_bar} !== 2'b11) begin
            errors++;
            $display("FAIL fill_stall got stall=%b w_bar=%b exp 1 1", wsyn_stall, w_bar);
        end
        tick();
        checks++;
        if ({wsyn_stall, w_bar, a, d, count, in_ready} !== {1'b0, 1'b0, fa[0], fd[0], 4'd7, 1'b1}) begin
            errors++;
            $display("FAIL fill_release got stall=%b w_bar=%b a=%h d=%h count=%0d rdy=%b exp 0 0 %h %h 7 1",
                     wsyn_stall, w_bar, a, d, count, in_ready, fa[0], fd[0]);
        end
        for (int i = 1; i < 8; i++) begin
            tick(); tick(); tick();
            checks++;
            if ({w_bar, a, d, count} !== {1'b0, fa[i], fd[i], 4'(7 - i)}) begin
                errors++;
                $display("FAIL fill_order i=%0d got w_bar=%b a=%h d=%h count=%0d exp 0 %h %h %0d",
                         i, w_bar, a, d, count, fa[i], fd[i], 7 - i);
            end
        end
        tick(); tick(); tick();
        checks++;
        if ({w_bar, count, a} !== {1'b1, 4'd0, fa[7]}) begin
            errors++;
            $display("FAIL fill_drained got w_bar=%b count=%0d a=%h exp 1 0 %h", w_bar, count, a, fa[7]);
        end
    endtask

    task automatic test_wsync();
        do_reset();
        in_valid = 1'b1; in_addr = 6'h02; in_data = 8'h00;
        tick();
        in_addr = 6'h2A; in_data = 8'h77; line_start = 1'b1;
        tick();
        in_valid = 1'b0; line_start = 1'b0;
        tick();
        checks++;
        if ({a, w_bar, wsyn_stall} !== {6'h02, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wsync_issue got a=%h w_bar=%b stall=%b exp 02 0 0", a, w_bar, wsyn_stall);
        end
        tick(); tick(); tick();
        checks++;
        if ({wsyn_stall, w_bar, count, a} !== {1'b1, 1'b1, 4'd1, 6'h02}) begin
            errors++;
            $display("FAIL wsync_enter got stall=%b w_bar=%b count=%0d a=%h exp 1 1 1 02", wsyn_stall, w_bar, count, a);
        end
        for (int k = 7; k <= 39; k++) begin
            tick();
            checks++;
            if ({wsyn_stall, w_bar} !== 2'b11) begin
                errors++;
                $display("FAIL wsync_hold edge=%0d got stall=%b w_bar=%b exp 1 1", k, wsyn_stall, w_bar);
            end
        end
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        checks++;
        if ({wsyn_stall, w_bar} !== 2'b11) begin
            errors++;
            $display("FAIL wsync_wait_boundary got stall=%b w_bar=%b exp 1 1", wsyn_stall, w_bar);
        end
        tick();
        checks++;
        if ({wsyn_stall, w_bar, a, d, count} !== {1'b0, 1'b0, 6'h2A, 8'h77, 4'd0}) begin
            errors++;
            $display("FAIL wsync_resume got stall=%b w_bar=%b a=%h d=%h count=%0d exp 0 0 2a 77 0",
                     wsyn_stall, w_bar, a, d, count);
        end
    endtask

    task automatic test_wsync_nostall();
        do_reset();
        in_valid = 1'b1; in_addr = 6'h02; in_data = 8'h00;
        tick();
        in_addr = 6'h15; in_data = 8'h9C;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({wsyn_stall, w_bar, a} !== {1'b0, 1'b0, 6'h02}) begin
            errors++;
            $display("FAIL nostall_cycle got stall=%b w_bar=%b a=%h exp 0 0 02", wsyn_stall, w_bar, a);
        end
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        checks++;
        if ({wsyn_stall, w_bar, a, d, count} !== {1'b0, 1'b0, 6'h15, 8'h9C, 4'd0}) begin
            errors++;
            $display("FAIL nostall_next got stall=%b w_bar=%b a=%h d=%h count=%0d exp 0 0 15 9c 0",
                     wsyn_stall, w_bar, a, d, count);
        end
        tick(); tick(); tick();
        checks++;
        if ({wsyn_stall, w_bar} !== 2'b01) begin
            errors++;
            $display("FAIL nostall_idle got stall=%b w_bar=%b exp 0 1", wsyn_stall, w_bar);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_addr = 6'(6'h20 + i); in_data = 8'(8'hC0 + i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if ({count, w_bar, a, d} !== {4'd5, 1'b0, 6'h21, 8'hC1}) begin
            errors++;
            $display("FAIL midflight_pre got count=%0d w_bar=%b a=%h d=%h exp 5 0 21 c1", count, w_bar, a, d);
        end
        reset_bar = 1'b0;
        tick();
        checks++;
        if ({w_bar, count, phi2, a, d, in_ready, wsyn_stall} !== {1'b1, 4'd0, 1'b1, 6'h00, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midflight_reset got w_bar=%b count=%0d phi2=%b a=%h d=%h rdy=%b stall=%b exp 1 0 1 00 00 1 0",
                     w_bar, count, phi2, a, d, in_ready, wsyn_stall);
        end
        reset_bar = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({phi2, w_bar, count} !== {((k % 3) == 0), 1'b1, 4'd0}) begin
                errors++;
                $display("FAIL midflight_after edge=%0d got phi2=%b w_bar=%b count=%0d exp %b 1 0",
                         k, phi2, w_bar, count, ((k % 3) == 0));
            end
        end
    endtask

    initial begin
        reset_bar  = 1'b0;
        in_valid   = 1'b0;
        in_addr    = 6'h00;
        in_data    = 8'h00;
        line_start = 1'b0;
        test_reset();
        test_two_writes();
        test_fill();
        test_wsync();
        test_wsync_nostall();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
